// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C bit-level sequencer: command and phase
// encodings, phase count, and the per-phase SCL/SDA level table.
package i2c_pkg;

  localparam int PHASES = 4;

  typedef enum logic [1:0] {
    CMD_START = 2'b00,
    CMD_STOP  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_READ  = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH_A = 3'd1,
    PH_B = 3'd2,
    PH_C = 3'd3,
    PH_D = 3'd4
  } state_t;

  // Line levels {scl, sda} for a command in a given phase; 1 = released.
  function automatic logic [1:0] line_levels(cmd_t cmd, state_t st, logic din);
    logic [1:0] lv;
    lv = 2'b11;
    case (cmd)
      CMD_START: begin
        case (st)
          PH_C:    lv = 2'b10;
          PH_D:    lv = 2'b00;
          default: lv = 2'b11;
        endcase
      end
      CMD_STOP: begin
        case (st)
          PH_A:       lv = 2'b00;
          PH_B, PH_C: lv = 2'b10;
          default:    lv = 2'b11;
        endcase
      end
      CMD_WRITE: begin
        case (st)
          PH_B, PH_C: lv = {1'b1, din};
          default:    lv = {1'b0, din};
        endcase
      end
      default: begin
        case (st)
          PH_B, PH_C: lv = 2'b11;
          default:    lv = 2'b01;
        endcase
      end
    endcase
    return lv;
  endfunction

endpackage

// File: rtl/i2c_phase_ticker.sv
// Phase ticker: down-counter that emits Tick on zero and reloads Value.
// Hold freezes the count and suppresses Tick (used for clock stretching).
module i2c_phase_ticker #(
  parameter int SIZE = 8
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Load,
  input  logic            Hold,
  input  logic [SIZE-1:0] Value,
  output logic            Tick
);

  logic [SIZE-1:0] count_reg;

  assign Tick = (count_reg == '0) && !Hold;

  // Count down, reload on terminal count, freeze while held.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      count_reg <= '0;
    end else if (Load) begin
      count_reg <= Value;
    end else if (Hold) begin
      count_reg <= count_reg;
    end else if (count_reg == '0) begin
      count_reg <= Value;
    end else begin
      count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/i2c_bit_ctrl.sv
// Bit-level I2C master sequencer: runs START/STOP/WRITE/READ as four
// ticker-timed phases, drives open-drain enables, samples SDA on READ and
// flags arbitration loss. Optional clock stretching: I2C_CLK_STRETCH_EN.
module i2c_bit_ctrl
  import i2c_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [SIZE-1:0] Prescale,
  input  logic [1:0]      Cmd,
  input  logic            Cmd_valid,
  output logic            Cmd_ready,
  input  logic            Din,
  output logic            Dout,
  output logic            Done,
  output logic            Al,
  output logic            Busy,
  input  logic            SCL_i,
  input  logic            SDA_i,
  output logic            SCL_oen,
  output logic            SDA_oen
);

  state_t          state_reg, state_next;
  cmd_t            cmd_reg, cmd_eff;
  logic            din_reg, din_eff;
  logic [SIZE-1:0] prescale_reg;
  logic            scl_reg, scl_next, sda_reg, sda_next;
  logic            dout_reg, dout_next, done_reg, done_next, al_reg, al_next;
  logic            accept, tick, hold, arb_lost;
  logic [1:0]      lv;

  assign accept   = Cmd_valid && (state_reg == IDLE);
  assign cmd_eff  = accept ? cmd_t'(Cmd) : cmd_reg;
  assign din_eff  = accept ? Din : din_reg;
  assign arb_lost = (cmd_reg == CMD_WRITE) && din_reg && !SDA_i;

`ifdef I2C_CLK_STRETCH_EN
  assign hold = ((state_reg == PH_B) || (state_reg == PH_C)) && scl_reg && !SCL_i;
`else
  logic scl_unused;
  assign scl_unused = SCL_i;
  assign hold       = 1'b0;
`endif

  i2c_phase_ticker #(.SIZE(SIZE)) u_ticker (
    .Clk   (Clk),
    .Rst   (Rst),
    .Load  (accept),
    .Hold  (hold),
    .Value (accept ? Prescale : prescale_reg),
    .Tick  (tick)
  );

  // Latch the command parameters so mid-command input changes are ignored.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cmd_reg      <= CMD_START;
      din_reg      <= 1'b0;
      prescale_reg <= '0;
    end else if (accept) begin
      cmd_reg      <= cmd_t'(Cmd);
      din_reg      <= Din;
      prescale_reg <= Prescale;
    end
  end

  // State register and registered outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg <= IDLE;
      scl_reg   <= 1'b1;
      sda_reg   <= 1'b1;
      dout_reg  <= 1'b0;
      done_reg  <= 1'b0;
      al_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      scl_reg   <= scl_next;
      sda_reg   <= sda_next;
      dout_reg  <= dout_next;
      done_reg  <= done_next;
      al_reg    <= al_next;
    end
  end

  // Next-state: one phase per tick; arbitration loss aborts at end of B.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = PH_A;
      PH_A:    if (tick) state_next = PH_B;
      PH_B:    if (tick) state_next = arb_lost ? IDLE : PH_C;
      PH_C:    if (tick) state_next = PH_D;
      PH_D:    if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: line levels of the phase being entered, sample and pulses.
  always_comb begin
    lv        = line_levels(cmd_eff, state_next, din_eff);
    scl_next  = scl_reg;
    sda_next  = sda_reg;
    dout_next = dout_reg;
    done_next = 1'b0;
    al_next   = 1'b0;
    if (state_next != IDLE) begin
      scl_next = lv[1];
      sda_next = lv[0];
    end
    if ((state_reg == PH_B) && tick) begin
      if (cmd_reg == CMD_READ) dout_next = SDA_i;
      if (arb_lost) begin
        al_next  = 1'b1;
        scl_next = 1'b1;
        sda_next = 1'b1;
      end
    end
    if ((state_reg == PH_D) && tick) done_next = 1'b1;
  end

  assign Cmd_ready = (state_reg == IDLE);
  assign Busy      = (state_reg != IDLE);
  assign SCL_oen   = scl_reg;
  assign SDA_oen   = sda_reg;
  assign Dout      = dout_reg;
  assign Done      = done_reg;
  assign Al        = al_reg;

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Self-checking bench for i2c_bit_ctrl; expected completions are queued at
// issue time and popped when the DUT reports Done or Al.
module tb_i2c_bit_ctrl;
  import i2c_pkg::*;

  logic       Clk = 1'b0;
  logic       Rst, Cmd_valid, Din, SCL_i, SDA_i;
  logic [7:0] Prescale;
  logic [1:0] Cmd;
  logic       Cmd_ready, Dout, Done, Al, Busy, SCL_oen, SDA_oen;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string tag;
    int    lat;
    logic  al;
    logic  chk_dout;
    logic  dout;
  } exp_t;
  exp_t sb[$];

  always #5 Clk = ~Clk;

  i2c_bit_ctrl #(.SIZE(8)) dut (
    .Clk(Clk), .Rst(Rst), .Prescale(Prescale), .Cmd(Cmd), .Cmd_valid(Cmd_valid),
    .Cmd_ready(Cmd_ready), .Din(Din), .Dout(Dout), .Done(Done), .Al(Al),
    .Busy(Busy), .SCL_i(SCL_i), .SDA_i(SDA_i), .SCL_oen(SCL_oen), .SDA_oen(SDA_oen)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // Issue one command and follow it to Done/Al; returns fall cycles of the lines.
  task automatic run_cmd(input string tag, input logic [1:0] c, input logic d,
                         input logic [7:0] pre, input logic sda, input int stretch_len,
                         input int hold_valid, input logic chg_pre, input int exp_lat,
                         input logic exp_al, input logic chk_dout, input logic exp_dout,
                         output int sda_fall, output int scl_fall, output logic sda_low);
    exp_t e;
    int   n;
    logic seen, prev_sda, prev_scl;
    e.tag = tag; e.lat = exp_lat; e.al = exp_al; e.chk_dout = chk_dout; e.dout = exp_dout;
    sb.push_back(e);
    chk({tag, "_ready"}, Cmd_ready, 1);
    Cmd = c; Din = d; Prescale = pre; SDA_i = sda; Cmd_valid = 1'b1;
    prev_sda = SDA_oen; prev_scl = SCL_oen;
    cyc();
    Din = ~d;
    if (chg_pre) Prescale = 8'd0;
    if (hold_valid == 0) Cmd_valid = 1'b0;
    n = 0; seen = 1'b0; sda_fall = 0; scl_fall = 0; sda_low = 1'b0;
    while (!seen && n < 200) begin
      cyc();
      n++;
      if (n >= hold_valid) Cmd_valid = 1'b0;
      SCL_i = (stretch_len > 0 && n >= 5 && n < 5 + stretch_len) ? 1'b0 : 1'b1;
      if (!SDA_oen) sda_low = 1'b1;
      if (prev_sda && !SDA_oen && sda_fall == 0) sda_fall = n;
      if (prev_scl && !SCL_oen && scl_fall == 0) scl_fall = n;
      prev_sda = SDA_oen; prev_scl = SCL_oen;
      if (Done || Al) seen = 1'b1;
    end
    e = sb.pop_front();
    chk({e.tag, "_latency"}, seen ? n : -1, e.lat);
    chk({e.tag, "_al"}, Al, e.al);
    chk({e.tag, "_done"}, Done, !e.al);
    if (e.chk_dout) chk({e.tag, "_dout"}, Dout, e.dout);
    $display("txn %s cmd=%0d lat=%0d done=%0b al=%0b dout=%0b", e.tag, c, n, Done, Al, Dout);
    SDA_i = 1'b1; SCL_i = 1'b1; Prescale = pre;
  endtask

  initial begin
    int   sf, cf;
    logic sl;
    int   stretch_lat;
    Rst = 1'b1; Cmd_valid = 1'b0; Cmd = 2'b00; Din = 1'b0; Prescale = 8'd3;
    SCL_i = 1'b1; SDA_i = 1'b1;
    cyc(); cyc();
    Rst = 1'b0;
    cyc();
    chk("rst_scl", SCL_oen, 1);
    chk("rst_sda", SDA_oen, 1);
    chk("rst_ready", Cmd_ready, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_al", Al, 0);
    chk("rst_dout", Dout, 0);

    // START, Prescale=3: SDA falls entering C, SCL falls entering D
    run_cmd("start_p3", CMD_START, 1'b0, 8'd3, 1'b1, 0, 0, 1'b0, PHASES * 4, 1'b0, 1'b0, 1'b0, sf, cf, sl);
    chk("start_sda_fall", sf, 8);
    chk("start_scl_fall", cf, 12);

    // WRITE 0 then READ: READ must keep SDA released throughout
    run_cmd("write0", CMD_WRITE, 1'b0, 8'd3, 1'b1, 0, 0, 1'b0, 16, 1'b0, 1'b0, 1'b0, sf, cf, sl);
    chk("write0_sda_low", sl, 1);
    run_cmd("read1", CMD_READ, 1'b0, 8'd3, 1'b1, 0, 0, 1'b0, 16, 1'b0, 1'b1, 1'b1, sf, cf, sl);
    chk("read1_sda_low", sl, 0);
    run_cmd("read0", CMD_READ, 1'b1, 8'd3, 1'b0, 0, 0, 1'b0, 16, 1'b0, 1'b1, 1'b0, sf, cf, sl);
    run_cmd("read1b", CMD_READ, 1'b0, 8'd3, 1'b1, 0, 0, 1'b0, 16, 1'b0, 1'b1, 1'b1, sf, cf, sl);
    run_cmd("write1_ok", CMD_WRITE, 1'b1, 8'd3, 1'b1, 0, 0, 1'b0, 16, 1'b0, 1'b1, 1'b1, sf, cf, sl);

    // Reset asserted for two cycles in the middle of a WRITE 0
    Cmd = CMD_WRITE; Din = 1'b0; Prescale = 8'd3; Cmd_valid = 1'b1;
    cyc();
    Cmd_valid = 1'b0;
    repeat (5) cyc();
    chk("midwr_sda_low", SDA_oen, 0);
    Rst = 1'b1;
    cyc(); cyc();
    Rst = 1'b0;
    cyc();
    chk("midrst_scl", SCL_oen, 1);
    chk("midrst_sda", SDA_oen, 1);
    chk("midrst_ready", Cmd_ready, 1);
    chk("midrst_done", Done, 0);
    chk("midrst_al", Al, 0);
    chk("midrst_dout", Dout, 0);
    $display("txn midcmd_reset scl=%0b sda=%0b ready=%0b", SCL_oen, SDA_oen, Cmd_ready);

    // Arbitration loss: WRITE 1 while another master pulls SDA low
    run_cmd("arb", CMD_WRITE, 1'b1, 8'd3, 1'b0, 0, 0, 1'b0, 8, 1'b1, 1'b0, 1'b0, sf, cf, sl);
    chk("arb_scl_rel", SCL_oen, 1);
    chk("arb_sda_rel", SDA_oen, 1);
    chk("arb_ready", Cmd_ready, 1);
    cyc();
    chk("arb_al_pulse", Al, 0);
    chk("arb_no_done", Done, 0);

    // STOP at Prescale=0 with Cmd_valid held through Busy
    run_cmd("stop_p0", CMD_STOP, 1'b0, 8'd0, 1'b1, 0, 3, 1'b0, 4, 1'b0, 1'b0, 1'b0, sf, cf, sl);
    chk("stop_scl", SCL_oen, 1);
    chk("stop_sda", SDA_oen, 1);
    cyc();
    chk("stop_no_reaccept1", Busy, 0);
    cyc();
    chk("stop_no_reaccept2", Busy, 0);

    // Prescale change mid-command, and a longer phase length
    run_cmd("pre_chg", CMD_WRITE, 1'b0, 8'd3, 1'b1, 0, 0, 1'b1, 16, 1'b0, 1'b0, 1'b0, sf, cf, sl);
    run_cmd("start_p5", CMD_START, 1'b0, 8'd5, 1'b1, 0, 0, 1'b0, PHASES * 6, 1'b0, 1'b0, 1'b0, sf, cf, sl);

    // SCL held low by a slave for 10 cycles during phase B
`ifdef I2C_CLK_STRETCH_EN
    stretch_lat = 26;
`else
    stretch_lat = 16;
`endif
    run_cmd("stretch", CMD_WRITE, 1'b0, 8'd3, 1'b1, 10, 0, 1'b0, stretch_lat, 1'b0, 1'b0, 1'b0, sf, cf, sl);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
